// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: default geometry, skew-buffer FSM states
// and the lane slicing helper used by the serializer, skew buffer and PE array.
package cnn_pkg;

    localparam int unsigned DEF_WORDWIDTH = 32;
    localparam int unsigned DEF_ARRAYLEN  = 25;
    localparam int unsigned DEF_VECWIDTH  = DEF_WORDWIDTH * DEF_ARRAYLEN;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } skew_state_e;

    // Lane k of a default-geometry receptive-field vector.
    function automatic logic [DEF_WORDWIDTH-1:0] lane_word(
        input logic [DEF_VECWIDTH-1:0] vec,
        input int unsigned             k
    );
        logic [DEF_VECWIDTH-1:0] w_shifted;
        w_shifted = vec >> (k * DEF_WORDWIDTH);
        return w_shifted[DEF_WORDWIDTH-1:0];
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// DEPTH-stage {valid, word} shift register; the word output is forced to zero
// whenever the emerging stage is invalid so downstream sees clean padding.
module skew_delay_line #(
    parameter int unsigned WORDWIDTH = 32,
    parameter int unsigned DEPTH     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    input  logic [WORDWIDTH-1:0] i_word,
    output logic                 o_valid,
    output logic [WORDWIDTH-1:0] o_word
);

    localparam int unsigned VW = DEPTH * WORDWIDTH;

    logic [DEPTH-1:0]     r_valid;
    logic [VW-1:0]        r_word;
    logic [WORDWIDTH-1:0] w_in_word;

    assign w_in_word = i_valid ? i_word : '0;

    // Stage 0 sits in the LSBs; the concatenate-and-truncate shift also covers DEPTH=1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_word  <= '0;
        end else begin
            r_valid <= DEPTH'({r_valid, i_valid});
            r_word  <= VW'({r_word, w_in_word});
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_word  = r_valid[DEPTH-1] ? r_word[VW-1 -: WORDWIDTH] : '0;

endmodule

// File: rtl/rf_skew_buffer.sv
// Receptive-field skew buffer: delays lane k by k+1 cycles to form the systolic
// wavefront, and tracks tile boundaries with a drain phase and a done pulse.
module rf_skew_buffer
    import cnn_pkg::*;
#(
    parameter int unsigned WORDWIDTH = DEF_WORDWIDTH,
    parameter int unsigned ARRAYLEN  = DEF_ARRAYLEN
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ARRAYLEN*WORDWIDTH-1:0] din,
    input  logic                          in_valid,
    input  logic                          in_last,
    output logic                          in_ready,
    output logic [ARRAYLEN*WORDWIDTH-1:0] dout,
    output logic [ARRAYLEN-1:0]           lane_valid,
    output logic                          busy,
    output logic                          done
);

    localparam int unsigned   CW         = (ARRAYLEN > 1) ? $clog2(ARRAYLEN) : 1;
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(ARRAYLEN - 1);

    skew_state_e   r_state;
    logic [CW-1:0] r_drain_cnt;
    logic          r_in_ready;
    logic          r_busy;
    logic          r_done;
    logic          w_accept;

    assign w_accept = in_valid && r_in_ready;

    // Counter is loaded with ARRAYLEN-1 and leaves DRAIN as it steps 1->0, so
    // IDLE and done coincide with the last word leaving the deepest lane.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_drain_cnt <= '0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE, RUN: begin
                    if (w_accept) begin
                        if (!in_last) begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                        end else if (ARRAYLEN == 1) begin
                            r_state    <= IDLE;
                            r_in_ready <= 1'b1;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                        end else begin
                            r_state     <= DRAIN;
                            r_drain_cnt <= DRAIN_LOAD;
                            r_in_ready  <= 1'b0;
                            r_busy      <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (r_drain_cnt == CW'(1)) begin
                        r_state     <= IDLE;
                        r_drain_cnt <= '0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_drain_cnt <= '0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = r_in_ready;
    assign busy     = r_busy;
    assign done     = r_done;

    for (genvar k = 0; k < ARRAYLEN; k++) begin : g_lane
        logic [WORDWIDTH-1:0] w_lane_in;

        assign w_lane_in = din[k*WORDWIDTH +: WORDWIDTH];

        skew_delay_line #(
            .WORDWIDTH (WORDWIDTH),
            .DEPTH     (k + 1)
        ) u_line (
            .clk     (clk),
            .rst     (rst),
            .i_valid (w_accept),
            .i_word  (w_lane_in),
            .o_valid (lane_valid[k]),
            .o_word  (dout[k*WORDWIDTH +: WORDWIDTH])
        );
    end

endmodule

// File: tb/tb_rf_skew_buffer.sv
// Scoreboard bench for rf_skew_buffer: a 4x8 instance checked through per-lane
// expectation queues, plus a default-geometry instance checked directly.
module tb_rf_skew_buffer;

    logic        clk;
    logic        rst;
    logic [31:0] din;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] dout;
    logic [3:0]  lane_valid;
    logic        busy;
    logic        done;

    logic [799:0] b_din;
    logic         b_in_valid;
    logic         b_in_last;
    logic         b_in_ready;
    logic [799:0] b_dout;
    logic [24:0]  b_lane_valid;
    logic         b_busy;
    logic         b_done;

    int cyc;
    int n_cmp;
    int n_bad;
    bit mon_en;

    typedef struct {
        int         cyc;
        logic [7:0] w;
    } exp_t;

    exp_t lq[4][$];
    int   dq[$];

    rf_skew_buffer #(.WORDWIDTH(8), .ARRAYLEN(4)) dut (
        .clk(clk), .rst(rst), .din(din), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .dout(dout), .lane_valid(lane_valid), .busy(busy), .done(done)
    );

    rf_skew_buffer #(.WORDWIDTH(32), .ARRAYLEN(25)) dut_big (
        .clk(clk), .rst(rst), .din(b_din), .in_valid(b_in_valid), .in_last(b_in_last),
        .in_ready(b_in_ready), .dout(b_dout), .lane_valid(b_lane_valid), .busy(b_busy),
        .done(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step(input logic [31:0] v, input logic val, input logic lst);
        @(negedge clk);
        din      = v;
        in_valid = val;
        in_last  = lst;
    endtask

    task automatic push_vec(input logic [31:0] v, input int t);
        for (int k = 0; k < 4; k++) begin
            exp_t e;
            e.cyc = t + k + 1;
            e.w   = 8'(v >> (8 * k));
            lq[k].push_back(e);
        end
    endtask

    // Monitor: every presented lane word must match the oldest expectation for that lane.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 4; k++) begin
                logic [7:0] w;
                logic       lv;
                exp_t       e;
                w  = 8'(dout >> (8 * k));
                lv = 1'((lane_valid >> k) & 4'd1);
                if (lv) begin
                    if (lq[k].size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL lane%0d_unexpected: got %0h expected no data (cycle %0d)", k, w, cyc);
                    end else begin
                        e = lq[k].pop_front();
                        chk($sformatf("lane%0d_cycle", k), cyc, e.cyc);
                        chk($sformatf("lane%0d_word", k), {24'd0, w}, {24'd0, e.w});
                    end
                end else begin
                    chk($sformatf("lane%0d_zero_pad", k), {24'd0, w}, 32'd0);
                end
            end
            if (done) begin
                if (dq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL done_unexpected: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    chk("done_cycle", cyc, dq.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        int tb;
        n_cmp      = 0;
        n_bad      = 0;
        mon_en     = 1'b0;
        rst        = 1'b1;
        din        = '0;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        b_din      = '0;
        b_in_valid = 1'b0;
        b_in_last  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_dout", dout, 32'd0);
        chk("rst_lane_valid", {28'd0, lane_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_big_ready", {31'd0, b_in_ready}, 32'd1);
        chk("rst_big_valid", {7'd0, b_lane_valid}, 32'd0);
        mon_en = 1'b1;

        // single-vector tile
        step(32'h04030201, 1'b1, 1'b1);
        t = cyc;
        push_vec(32'h04030201, t);
        dq.push_back(t + 4);
        for (int i = 1; i <= 3; i++) begin
            step(32'd0, 1'b0, 1'b0);
            chk("t1_ready_drain", {31'd0, in_ready}, 32'd0);
            chk("t1_busy_drain", {31'd0, busy}, 32'd1);
        end
        step(32'd0, 1'b0, 1'b0);
        chk("t1_ready_done", {31'd0, in_ready}, 32'd1);
        chk("t1_busy_done", {31'd0, busy}, 32'd0);
        chk("t1_done", {31'd0, done}, 32'd1);
        step(32'd0, 1'b0, 1'b0);

        // streaming: three back-to-back vectors
        begin
            logic [3:0] pat [7];
            pat = '{4'b0111, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
            step(32'h13121110, 1'b1, 1'b0);
            t = cyc;
            push_vec(32'h13121110, t);
            step(32'h23222120, 1'b1, 1'b0);
            push_vec(32'h23222120, t + 1);
            chk("t2_lv_c1", {28'd0, lane_valid}, 32'b0001);
            step(32'h33323130, 1'b1, 1'b1);
            push_vec(32'h33323130, t + 2);
            dq.push_back(t + 6);
            chk("t2_lv_c2", {28'd0, lane_valid}, 32'b0011);
            for (int i = 0; i < 5; i++) begin
                step(32'd0, 1'b0, 1'b0);
                chk($sformatf("t2_lv_c%0d", i + 3), {28'd0, lane_valid}, {28'd0, pat[i]});
            end
        end

        // bubble between two vectors
        step(32'h43424140, 1'b1, 1'b0);
        t = cyc;
        push_vec(32'h43424140, t);
        step(32'd0, 1'b0, 1'b0);
        chk("t3_busy_bubble", {31'd0, busy}, 32'd1);
        chk("t3_lv_c1", {28'd0, lane_valid}, 32'b0001);
        step(32'h53525150, 1'b1, 1'b1);
        push_vec(32'h53525150, t + 2);
        dq.push_back(t + 6);
        chk("t3_lv_c2", {28'd0, lane_valid}, 32'b0010);
        step(32'd0, 1'b0, 1'b0);
        chk("t3_lv_c3", {28'd0, lane_valid}, 32'b0101);
        repeat (4) step(32'd0, 1'b0, 1'b0);

        // back-pressure: FF vectors offered while draining must be dropped
        step(32'h63626160, 1'b1, 1'b1);
        t = cyc;
        push_vec(32'h63626160, t);
        dq.push_back(t + 4);
        for (int i = 1; i <= 3; i++) begin
            step(32'hFFFFFFFF, 1'b1, 1'b0);
            chk("t4_ready_drain", {31'd0, in_ready}, 32'd0);
        end
        step(32'hA3A2A1A0, 1'b1, 1'b1);
        chk("t4_ready_done", {31'd0, in_ready}, 32'd1);
        push_vec(32'hA3A2A1A0, t + 4);
        dq.push_back(t + 8);
        repeat (3) step(32'hFFFFFFFF, 1'b1, 1'b0);
        repeat (3) step(32'd0, 1'b0, 1'b0);

        // reset in the second drain cycle discards the tile
        step(32'h73727170, 1'b1, 1'b1);
        t = cyc;
        begin
            exp_t e;
            e.cyc = t + 1; e.w = 8'h70; lq[0].push_back(e);
            e.cyc = t + 2; e.w = 8'h71; lq[1].push_back(e);
        end
        step(32'd0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_dout", dout, 32'd0);
        chk("t5_lane_valid", {28'd0, lane_valid}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_ready", {31'd0, in_ready}, 32'd1);
        chk("t5_done", {31'd0, done}, 32'd0);
        repeat (6) step(32'd0, 1'b0, 1'b0);

        // default geometry: lane k carries k+1
        @(negedge clk);
        b_din = '0;
        for (int k = 0; k < 25; k++) b_din = b_din | (800'(k + 1) << (32 * k));
        b_in_valid = 1'b1;
        b_in_last  = 1'b1;
        tb = cyc;
        @(negedge clk);
        b_in_valid = 1'b0;
        b_in_last  = 1'b0;
        chk("big_ready_drain", {31'd0, b_in_ready}, 32'd0);
        for (int j = 1; j <= 25; j++) begin
            chk($sformatf("big_cycle_%0d", j), cyc, tb + j);
            chk($sformatf("big_lv_%0d", j), {7'd0, b_lane_valid}, {7'd0, 25'd1 << (j - 1)});
            chk($sformatf("big_word_%0d", j), 32'(b_dout >> (32 * (j - 1))), 32'(j));
            chk($sformatf("big_done_%0d", j), {31'd0, b_done}, (j == 25) ? 32'd1 : 32'd0);
            if (j < 25) @(negedge clk);
        end
        chk("big_ready_done", {31'd0, b_in_ready}, 32'd1);
        chk("big_busy_done", {31'd0, b_busy}, 32'd0);

        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) chk($sformatf("lane%0d_left_over", k), lq[k].size(), 32'd0);
        chk("done_left_over", dq.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
